uart_tx_sched: RTL and testbench

Transmit-side controller for the 8051 UART. It drains bytes from the TX FIFO read port, serializes each byte as an asynchronous frame on `txd`, and reports completion for the SCON TI flag. It runs entirely in the FIFO read-clock domain and owns the FIFO's `r_en` and read-pointer reset.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_sched_if.sv | 26 ++
 rtl/uart_baud_timer.sv | 27 ++
 rtl/uart_tx_sched.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and parity helper
package uart_pkg;

  // Transmit controller states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int   UART_DATA_BITS = 8;
  localparam logic TXD_IDLE       = 1'b1;

  // Parity bit for a data byte: even parity when odd_sel is 0, odd parity when 1.
  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic odd_sel);
    return (^data) ^ odd_sel;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - TX FIFO read-port bundle between FIFO and transmit controller
interface uart_tx_sched_if;
  import uart_pkg::*;

  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_rd_en;
  logic                      fifo_rptr_rst_n;

  // Controller side: consumes FIFO status/data, drives read strobe and read-pointer reset.
  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en,
    output fifo_rptr_rst_n
  );

  // FIFO side.
  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en,
    input  fifo_rptr_rst_n
  );

endinterface

// File: rtl/uart_baud_timer.sv
// rtl/uart_baud_timer.sv - loadable bit-period down-counter shared by UART TX and RX
module uart_baud_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic [DIV_WIDTH-1:0] count,
  output logic                 tick
);

  // The last cycle of a bit period is the one where the counter sits at zero.
  assign tick = (count == '0);

  // Reload at each bit start, otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - UART transmit scheduler: drains TX FIFO and serializes frames on txd
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 flush,
  uart_tx_sched_if.master      fifo,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  // Index of the final stop bit; only 1 or 2 stop bits are meaningful.
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0]                bit_idx;
  logic                      stop_idx;
  logic [DIV_WIDTH-1:0]      div_q;
  logic                      par_en_q;
  logic                      par_bit;

  logic                      tmr_load;
  logic [DIV_WIDTH-1:0]      tmr_val;
  logic [DIV_WIDTH-1:0]      tmr_count;
  logic                      tmr_tick;

  logic                      start_ok;
  logic                      stop_last;

  assign start_ok  = tx_en && !fifo.fifo_empty && !flush;
  assign stop_last = (stop_idx == LAST_STOP);

  uart_baud_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .tick     (tmr_tick)
  );

  // Restart the bit timer at every bit boundary; LOAD uses the live divisor since div_q is latched on the same edge.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = div_q;
    case (state)
      ST_LOAD: begin
        tmr_load = 1'b1;
        tmr_val  = baud_div;
      end
      ST_START, ST_DATA, ST_PARITY: tmr_load = tmr_tick;
      ST_STOP:                      tmr_load = tmr_tick && !stop_last;
      default:                      tmr_load = 1'b0;
    endcase
  end

  // Frame sequencer; every output is registered and flush overrides any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= ST_IDLE;
      txd                  <= TXD_IDLE;
      busy                 <= 1'b0;
      tx_done              <= 1'b0;
      fifo.fifo_rd_en      <= 1'b0;
      fifo.fifo_rptr_rst_n <= 1'b1;
      shreg                <= '0;
      bit_idx              <= '0;
      stop_idx             <= 1'b0;
      div_q                <= '0;
      par_en_q             <= 1'b0;
      par_bit              <= 1'b0;
    end else begin
      fifo.fifo_rd_en      <= 1'b0;
      fifo.fifo_rptr_rst_n <= 1'b1;
      tx_done              <= 1'b0;
      if (flush) begin
        state                <= ST_IDLE;
        txd                  <= TXD_IDLE;
        busy                 <= 1'b0;
        fifo.fifo_rptr_rst_n <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            txd <= TXD_IDLE;
            if (start_ok) begin
              state           <= ST_FETCH;
              fifo.fifo_rd_en <= 1'b1;
              busy            <= 1'b1;
            end
          end
          ST_FETCH: begin
            state <= ST_LOAD;
          end
          ST_LOAD: begin
            shreg    <= fifo.fifo_rd_data;
            div_q    <= baud_div;
            par_en_q <= par_en;
            par_bit  <= calc_parity(fifo.fifo_rd_data, par_odd);
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            txd      <= 1'b0;
            state    <= ST_START;
          end
          ST_START: begin
            if (tmr_tick) begin
              txd   <= shreg[0];
              shreg <= shreg >> 1;
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (tmr_tick) begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == LAST_BIT) begin
                if (par_en_q) begin
                  txd   <= par_bit;
                  state <= ST_PARITY;
                end else begin
                  txd      <= 1'b1;
                  stop_idx <= 1'b0;
                  tx_done  <= !LAST_STOP && (div_q == '0);
                  state    <= ST_STOP;
                end
              end else begin
                txd   <= shreg[0];
                shreg <= shreg >> 1;
              end
            end
          end
          ST_PARITY: begin
            if (tmr_tick) begin
              txd      <= 1'b1;
              stop_idx <= 1'b0;
              tx_done  <= !LAST_STOP && (div_q == '0);
              state    <= ST_STOP;
            end
          end
          ST_STOP: begin
            txd <= 1'b1;
            if (tmr_tick) begin
              if (stop_last) begin
                if (tx_en && !fifo.fifo_empty) begin
                  state           <= ST_FETCH;
                  fifo.fifo_rd_en <= 1'b1;
                end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                stop_idx <= 1'b1;
                tx_done  <= (div_q == '0);
              end
            end else begin
              // Raise tx_done so it lands on the cycle where the final stop bit's timer hits zero.
              tx_done <= stop_last && (tmr_count == DIV_WIDTH'(1));
            end
          end
          default: begin
            state <= ST_IDLE;
            txd   <= TXD_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        par_en;
  logic        par_odd;
  logic        flush;
  logic        txd, busy, tx_done;
  logic        txd2, busy2, tx_done2;

  uart_tx_sched_if f1 ();
  uart_tx_sched_if f2 ();

  uart_tx_sched #(.DIV_WIDTH(16), .STOP_BITS(1)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_en    (tx_en),
    .baud_div (baud_div),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .flush    (flush),
    .fifo     (f1),
    .txd      (txd),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  uart_tx_sched #(.DIV_WIDTH(16), .STOP_BITS(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst2_n),
    .tx_en    (tx_en),
    .baud_div (baud_div),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .flush    (flush),
    .fifo     (f2),
    .txd      (txd2),
    .busy     (busy2),
    .tx_done  (tx_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models
  logic [7:0] mem1 [0:15];
  logic [7:0] mem2 [0:15];
  int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;

  assign f1.fifo_empty = (wp1 == rp1);
  assign f2.fifo_empty = (wp2 == rp2);

  // FIFO 1 read port: data valid the cycle after r_en, read pointer reset empties it
  always_ff @(posedge clk) begin
    if (!f1.fifo_rptr_rst_n) rp1 <= wp1;
    else if (f1.fifo_rd_en && (wp1 != rp1)) begin
      f1.fifo_rd_data <= mem1[rp1[3:0]];
      rp1 <= rp1 + 1;
    end
  end

  // FIFO 2 read port
  always_ff @(posedge clk) begin
    if (!f2.fifo_rptr_rst_n) rp2 <= wp2;
    else if (f2.fifo_rd_en && (wp2 != rp2)) begin
      f2.fifo_rd_data <= mem2[rp2[3:0]];
      rp2 <= rp2 + 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // expected and observed per-cycle streams, bit i = cycle i
  logic [255:0] e_txd, e_done, e_rd, e_busy, e_rst;
  logic [255:0] o_txd, o_done, o_rd, o_busy, o_rst;
  int e_len;

  function automatic void clear_exp();
    e_txd = '0; e_done = '0; e_rd = '0; e_busy = '0; e_rst = '0; e_len = 0;
  endfunction

  function automatic void put(input logic t, input logic d, input logic r,
                              input logic b, input logic rs);
    e_txd[e_len] = t; e_done[e_len] = d; e_rd[e_len] = r;
    e_busy[e_len] = b; e_rst[e_len] = rs;
    e_len++;
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) put(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic void truncate(input int n);
    for (int i = n; i < 256; i++) begin
      e_txd[i] = 1'b0; e_done[i] = 1'b0; e_rd[i] = 1'b0; e_busy[i] = 1'b0; e_rst[i] = 1'b0;
    end
    e_len = n;
  endfunction

  // FETCH, LOAD, then start/data/parity/stop bits of div+1 cycles each
  function automatic void add_frame(input logic [7:0] b, input bit pe, input bit po,
                                    input int div, input int stops);
    logic fb [0:11];
    int   nb;
    put(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    put(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    fb[0] = 1'b0;
    for (int k = 0; k < 8; k++) fb[k+1] = b[k];
    nb = 9;
    if (pe) begin fb[nb] = (^b) ^ po; nb++; end
    for (int s = 0; s < stops; s++) begin fb[nb] = 1'b1; nb++; end
    for (int k = 0; k < nb; k++)
      for (int c = 0; c <= div; c++)
        put(fb[k], (k == nb - 1) && (c == div), 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic int first_idx(input logic [255:0] v, input logic val, input int len);
    for (int i = 0; i < len; i++) if (v[i] === val) return i;
    return -1000;
  endfunction

  task automatic push1(input logic [7:0] b);
    mem1[wp1[3:0]] = b;
    wp1 = wp1 + 1;
  endtask

  task automatic push2(input logic [7:0] b);
    mem2[wp2[3:0]] = b;
    wp2 = wp2 + 1;
  endtask

  // sample DUT 1 each negedge; optionally drop tx_en or pulse flush after a given sample
  task automatic capture(input int len, input int drop_idx, input int flush_idx);
    o_txd = '0; o_done = '0; o_rd = '0; o_busy = '0; o_rst = '0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      o_txd[i] = txd; o_done[i] = tx_done; o_rd[i] = f1.fifo_rd_en;
      o_busy[i] = busy; o_rst[i] = f1.fifo_rptr_rst_n;
      if (i == drop_idx) tx_en = 1'b0;
      flush = (i == flush_idx);
    end
    flush = 1'b0;
  endtask

  logic [7:0] par_byte [0:2];
  logic       par_odd_v [0:2];
  logic       par_exp [0:2];
  int cnt_busy, cnt_rd;

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; tx_en = 1'b0; baud_div = 16'd3;
    par_en = 1'b0; par_odd = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", f1.fifo_rd_en, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_rptr", f1.fifo_rptr_rst_n, 1'b1);
    check("rst2_txd", txd2, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // single byte 8N1, div 3
    @(negedge clk);
    tx_en = 1'b1; baud_div = 16'd3; push1(8'hA5);
    clear_exp(); add_frame(8'hA5, 0, 0, 3, 1); add_idle(3);
    capture(e_len, -1, -1);
    check("s8n1_txd", o_txd, e_txd);
    check("s8n1_done", o_done, e_done);
    check("s8n1_rd", o_rd, e_rd);
    check("s8n1_busy", o_busy, e_busy);
    check("s8n1_rd_cnt", $countones(o_rd), 1);
    check("s8n1_done_cnt", $countones(o_done), 1);
    check("s8n1_len", first_idx(o_done, 1'b1, e_len) - first_idx(o_txd, 1'b0, e_len) + 1, 40);

    // parity cases
    par_byte[0] = 8'hA5; par_odd_v[0] = 1'b0; par_exp[0] = 1'b0;
    par_byte[1] = 8'hA5; par_odd_v[1] = 1'b1; par_exp[1] = 1'b1;
    par_byte[2] = 8'h01; par_odd_v[2] = 1'b1; par_exp[2] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      par_en = 1'b1; par_odd = par_odd_v[p]; push1(par_byte[p]);
      clear_exp(); add_frame(par_byte[p], 1, par_odd_v[p], 3, 1); add_idle(2);
      capture(e_len, -1, -1);
      check($sformatf("par%0d_txd", p), o_txd, e_txd);
      check($sformatf("par%0d_bit", p), o_txd[39], par_exp[p]);
      check($sformatf("par%0d_len", p),
            first_idx(o_done, 1'b1, e_len) - first_idx(o_txd, 1'b0, e_len) + 1, 44);
    end

    // burst of three, div 0
    @(negedge clk);
    par_en = 1'b0; par_odd = 1'b0; baud_div = 16'd0;
    push1(8'h11); push1(8'h22); push1(8'h33);
    clear_exp();
    add_frame(8'h11, 0, 0, 0, 1); add_frame(8'h22, 0, 0, 0, 1); add_frame(8'h33, 0, 0, 0, 1);
    add_idle(3);
    capture(e_len, -1, -1);
    check("burst_txd", o_txd, e_txd);
    check("burst_done", o_done, e_done);
    check("burst_rd", o_rd, e_rd);
    check("burst_busy", o_busy, e_busy);
    check("burst_done_cnt", $countones(o_done), 3);
    check("burst_rd_cnt", $countones(o_rd), 3);
    check("burst_end_busy", o_busy[e_len-1], 1'b0);

    // tx_en drop during DATA of first of two bytes
    @(negedge clk);
    baud_div = 16'd1; push1(8'h5A); push1(8'h3C);
    clear_exp(); add_frame(8'h5A, 0, 0, 1, 1); add_idle(4);
    capture(e_len, 6, -1);
    check("drop_txd", o_txd, e_txd);
    check("drop_busy", o_busy, e_busy);
    check("drop_rd_cnt", $countones(o_rd), 1);
    check("drop_done_cnt", $countones(o_done), 1);
    check("drop_empty", f1.fifo_empty, 1'b0);

    // drain leftover byte with a flush while idle
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    check("drain_rptr", f1.fifo_rptr_rst_n, 1'b0);
    check("drain_busy", busy, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    check("drain_empty", f1.fifo_empty, 1'b1);
    check("drain_rptr_back", f1.fifo_rptr_rst_n, 1'b1);

    // flush during bit 3 of 0xFF
    @(negedge clk);
    tx_en = 1'b1; baud_div = 16'd3; push1(8'hFF);
    clear_exp(); add_frame(8'hFF, 0, 0, 3, 1);
    truncate(20);
    put(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(5);
    capture(e_len, -1, 19);
    check("flush_txd", o_txd, e_txd);
    check("flush_busy", o_busy, e_busy);
    check("flush_rptr", o_rst, e_rst);
    check("flush_rd", o_rd, e_rd);
    check("flush_done_cnt", $countones(o_done), 0);
    check("flush_txd_next", o_txd[20], 1'b1);

    // reset mid-STOP on the two-stop-bit instance, div 1
    @(negedge clk);
    rst2_n = 1'b1; baud_div = 16'd1; push2(8'h00);
    repeat (23) @(negedge clk);
    check("rst2_pre_busy", busy2, 1'b1);
    check("rst2_pre_txd", txd2, 1'b1);
    rst2_n = 1'b0;
    #1;
    check("rst2_txd", txd2, 1'b1);
    check("rst2_busy", busy2, 1'b0);
    check("rst2_done", tx_done2, 1'b0);
    check("rst2_rd_en", f2.fifo_rd_en, 1'b0);
    check("rst2_rptr", f2.fifo_rptr_rst_n, 1'b1);
    tx_en = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    cnt_busy = 0; cnt_rd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt_busy += int'(busy2); cnt_rd += int'(f2.fifo_rd_en);
    end
    tx_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt_busy += int'(busy2); cnt_rd += int'(f2.fifo_rd_en);
    end
    check("rst2_quiet_busy", cnt_busy, 0);
    check("rst2_quiet_rd", cnt_rd, 0);
    push2(8'h81);
    @(negedge clk);
    check("rst2_restart_rd", f2.fifo_rd_en, 1'b1);
    check("rst2_restart_busy", busy2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
